// File: rtl/seq_mul_div.sv
`timescale 1ns / 1ps
// seq_mul_div: iterative multiply/divide unit, one result bit per clock.
//
// Computes WIDTH x WIDTH signed/unsigned products and signed/unsigned quotient and remainder.
// Signed operations run on operand magnitudes. The result sign is applied in a single FIX cycle.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   i_start       request, accepted only when idle
//   i_op          00 umul, 01 smul, 10 udiv, 11 sdiv (sampled with i_start)
//   i_a, i_b      multiplicand/dividend and multiplier/divisor (sampled with i_start)
//   o_busy        operation in flight
//   o_done        one-cycle pulse; o_hi/o_lo valid from this cycle
//   o_hi          mul: upper product half, div: remainder
//   o_lo          mul: lower product half, div: quotient
//   o_div_by_zero set with o_done for a divide with i_b == 0
module seq_mul_div #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_div_by_zero
);

  localparam int unsigned W2 = 2 * WIDTH;

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_mag_a;
  logic [WIDTH-1:0] r_mag_b;
  logic             r_res_sign;
  logic             r_div_sign;
  logic [CNT_W-1:0] r_cnt;
  // Multiply: {partial product high half, remaining multiplier bits}.
  // Divide:   {partial remainder, remaining dividend bits / quotient bits}.
  logic [W2-1:0]    r_acc;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;
  logic             r_dbz;

  // Operand magnitudes at start
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_start_div_zero;

  assign w_a_neg          = i_op[0] & i_a[WIDTH-1];
  assign w_b_neg          = i_op[0] & i_b[WIDTH-1];
  assign w_a_mag          = w_a_neg ? (~i_a + WIDTH'(1)) : i_a;
  assign w_b_mag          = w_b_neg ? (~i_b + WIDTH'(1)) : i_b;
  assign w_start_div_zero = i_op[1] & (i_b == '0);

  // Shift-add step: add the multiplicand when the current multiplier LSB is set, then shift right.
  logic [WIDTH:0]  w_mul_sum;
  logic [W2-1:0]   w_mul_acc;

  assign w_mul_sum = {1'b0, r_acc[W2-1:WIDTH]} + {1'b0, r_mag_a};
  assign w_mul_acc = r_acc[0] ? {w_mul_sum, r_acc[WIDTH-1:1]} : {1'b0, r_acc[W2-1:1]};

  // Restoring-division step. The WIDTH+1-bit trial difference is negative exactly when its top bit
  // is set, because the partial remainder is always below the divisor.
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH:0]   w_div_trial;
  logic             w_div_ok;
  logic [WIDTH-1:0] w_div_rem;
  logic [W2-1:0]    w_div_acc;

  assign w_div_shift = r_acc[W2-1:WIDTH-1];
  assign w_div_trial = w_div_shift - {1'b0, r_mag_b};
  assign w_div_ok    = ~w_div_trial[WIDTH];
  assign w_div_rem   = w_div_ok ? w_div_trial[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
  assign w_div_acc   = {w_div_rem, r_acc[WIDTH-2:0], w_div_ok};

  // Sign fix-up for the FIX cycle
  logic [W2-1:0]    w_prod;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_a_orig;
  logic             w_div_zero;

  assign w_prod     = r_res_sign ? (~r_acc + W2'(1)) : r_acc;
  assign w_quo      = r_res_sign ? (~r_acc[WIDTH-1:0] + WIDTH'(1)) : r_acc[WIDTH-1:0];
  assign w_rem      = r_div_sign ? (~r_acc[W2-1:WIDTH] + WIDTH'(1)) : r_acc[W2-1:WIDTH];
  // Re-negating the dividend magnitude restores the original bit pattern, including most-negative.
  assign w_a_orig   = r_div_sign ? (~r_mag_a + WIDTH'(1)) : r_mag_a;
  assign w_div_zero = r_op[1] & (r_mag_b == '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_next = w_start_div_zero ? StFix : StCalc;
        end
      end
      StCalc: begin
        if (r_cnt == CNT_W'(WIDTH - 1)) begin
          w_state_next = StFix;
        end
      end
      StFix:   w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op       <= '0;
      r_mag_a    <= '0;
      r_mag_b    <= '0;
      r_res_sign <= 1'b0;
      r_div_sign <= 1'b0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_dbz      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_op       <= i_op;
            r_mag_a    <= w_a_mag;
            r_mag_b    <= w_b_mag;
            r_res_sign <= w_a_neg ^ w_b_neg;
            r_div_sign <= w_a_neg;
            r_cnt      <= '0;
            r_dbz      <= 1'b0;
            // Multiply shifts the multiplier out of the low half; divide shifts the dividend out.
            r_acc      <= {{WIDTH{1'b0}}, (i_op[1] ? w_a_mag : w_b_mag)};
          end
        end
        StCalc: begin
          r_cnt <= r_cnt + 1'b1;
          r_acc <= r_op[1] ? w_div_acc : w_mul_acc;
        end
        StFix: begin
          r_done <= 1'b1;
          r_dbz  <= w_div_zero;
          if (!r_op[1]) begin
            r_hi <= w_prod[W2-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end else if (w_div_zero) begin
            r_hi <= w_a_orig;
            r_lo <= '1;
          end else begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy        = (r_state != StIdle);
  assign o_done        = r_done;
  assign o_hi          = r_hi;
  assign o_lo          = r_lo;
  assign o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_mul_div.sv
`timescale 1ns / 1ps
// tb_seq_mul_div: self-checking bench for seq_mul_div at WIDTH=32 and WIDTH=8.
// Expected results are queued when an operation is started and compared when done pulses.
module tb_seq_mul_div;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // 32-bit instance
  logic        s32_start = 1'b0;
  logic [1:0]  s32_op = '0;
  logic [31:0] s32_a = '0;
  logic [31:0] s32_b = '0;
  logic        d32_busy, d32_done, d32_dbz;
  logic [31:0] d32_hi, d32_lo;

  seq_mul_div #(.WIDTH(32)) u_dut32 (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (s32_start),
    .i_op         (s32_op),
    .i_a          (s32_a),
    .i_b          (s32_b),
    .o_busy       (d32_busy),
    .o_done       (d32_done),
    .o_hi         (d32_hi),
    .o_lo         (d32_lo),
    .o_div_by_zero(d32_dbz)
  );

  // 8-bit instance
  logic       s8_start = 1'b0;
  logic [1:0] s8_op = '0;
  logic [7:0] s8_a = '0;
  logic [7:0] s8_b = '0;
  logic       d8_busy, d8_done, d8_dbz;
  logic [7:0] d8_hi, d8_lo;

  seq_mul_div #(.WIDTH(8)) u_dut8 (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (s8_start),
    .i_op         (s8_op),
    .i_a          (s8_a),
    .i_b          (s8_b),
    .o_busy       (d8_busy),
    .o_done       (d8_done),
    .o_hi         (d8_hi),
    .o_lo         (d8_lo),
    .o_div_by_zero(d8_dbz)
  );

  typedef struct {
    logic [63:0] hi;
    logic [63:0] lo;
    logic        dbz;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  exp_t q32[$];
  exp_t q8[$];
  exp_t e32;
  exp_t e8;
  vec_t tab[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitors: every done pulse must match the oldest pending operation.
  always @(negedge clk) begin
    if (rst_n && d32_done) begin
      if (q32.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL done32_spurious: got done=1 required no pending op (t=%0t)", $time);
      end else begin
        e32 = q32.pop_front();
        chk("hi32", {32'b0, d32_hi}, e32.hi);
        chk("lo32", {32'b0, d32_lo}, e32.lo);
        chk("dbz32", {63'b0, d32_dbz}, {63'b0, e32.dbz});
        chk("busy_at_done32", {63'b0, d32_busy}, 64'd0);
        chk("latency32", 64'(cyc), 64'(e32.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && d8_done) begin
      if (q8.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL done8_spurious: got done=1 required no pending op (t=%0t)", $time);
      end else begin
        e8 = q8.pop_front();
        chk("hi8", {56'b0, d8_hi}, e8.hi);
        chk("lo8", {56'b0, d8_lo}, e8.lo);
        chk("dbz8", {63'b0, d8_dbz}, {63'b0, e8.dbz});
        chk("busy_at_done8", {63'b0, d8_busy}, 64'd0);
        chk("latency8", 64'(cyc), 64'(e8.cyc));
      end
    end
  end

  // Called at a falling edge; start is sampled on the following rising edge (E0).
  task automatic drive32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] hi, input logic [31:0] lo, input logic dbz);
    exp_t e;
    s32_op = op;
    s32_a = a;
    s32_b = b;
    s32_start = 1'b1;
    e.hi = {32'b0, hi};
    e.lo = {32'b0, lo};
    e.dbz = dbz;
    e.cyc = cyc + 1 + (dbz ? 1 : 33);
    q32.push_back(e);
    @(negedge clk);
    s32_start = 1'b0;
    s32_a = $urandom;
    s32_b = $urandom;
    s32_op = 2'($urandom);
  endtask

  task automatic drive8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] hi, input logic [7:0] lo, input logic dbz);
    exp_t e;
    s8_op = op;
    s8_a = a;
    s8_b = b;
    s8_start = 1'b1;
    e.hi = {56'b0, hi};
    e.lo = {56'b0, lo};
    e.dbz = dbz;
    e.cyc = cyc + 1 + (dbz ? 1 : 9);
    q8.push_back(e);
    @(negedge clk);
    s8_start = 1'b0;
    s8_a = 8'($urandom);
    s8_b = 8'($urandom);
    s8_op = 2'($urandom);
  endtask

  task automatic wait32();
    int n = 0;
    while (q32.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q32.size() != 0) begin
      failures++;
      $display("FAIL timeout32: got %0d pending ops required 0", q32.size());
      q32.delete();
    end
  endtask

  task automatic wait8();
    int n = 0;
    while (q8.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q8.size() != 0) begin
      failures++;
      $display("FAIL timeout8: got %0d pending ops required 0", q8.size());
      q8.delete();
    end
  endtask

  // Independent reference for WIDTH=8 using integer arithmetic.
  function automatic void model8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                 output logic [7:0] hi, output logic [7:0] lo, output logic dbz);
    int sa, sb, p, q, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    dbz = 1'b0;
    hi = '0;
    lo = '0;
    case (op)
      2'd0: begin
        p = int'(a) * int'(b);
        {hi, lo} = p[15:0];
      end
      2'd1: begin
        p = sa * sb;
        {hi, lo} = p[15:0];
      end
      default: begin
        if (b == 8'd0) begin
          dbz = 1'b1;
          lo = 8'hFF;
          hi = a;
        end else begin
          if (op == 2'd2) begin
            q = int'(a) / int'(b);
            r = int'(a) % int'(b);
          end else begin
            q = sa / sb;
            r = sa % sb;
          end
          lo = q[7:0];
          hi = r[7:0];
        end
      end
    endcase
  endfunction

  function automatic logic [7:0] pick8();
    case ($urandom_range(0, 7))
      0: return 8'h00;
      1: return 8'h01;
      2: return 8'h7F;
      3: return 8'h80;
      4: return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] a8, b8, hi8, lo8;
    logic [1:0] op8;
    logic       dbz8;
    int         n;

    tab[0]  = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    tab[1]  = '{2'd1, 32'hFFFF_FFF9, 32'd6,         32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0};
    tab[2]  = '{2'd2, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1};
    tab[3]  = '{2'd2, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    tab[4]  = '{2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0};
    tab[5]  = '{2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    tab[6]  = '{2'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    tab[7]  = '{2'd3, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1};
    tab[8]  = '{2'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
    tab[9]  = '{2'd0, 32'd3,         32'd5,         32'd0,         32'd15,        1'b0};
    tab[10] = '{2'd2, 32'hFFFF_FFFF, 32'h10,        32'hF,         32'h0FFF_FFFF, 1'b0};
    tab[11] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1,         1'b0};

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy32", {63'b0, d32_busy}, 64'd0);
    chk("rst_done32", {63'b0, d32_done}, 64'd0);
    chk("rst_hi32", {32'b0, d32_hi}, 64'd0);
    chk("rst_lo32", {32'b0, d32_lo}, 64'd0);
    chk("rst_dbz32", {63'b0, d32_dbz}, 64'd0);
    chk("rst_busy8", {63'b0, d8_busy}, 64'd0);
    chk("rst_lo8", {56'b0, d8_lo}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table at WIDTH=32
    for (int i = 0; i < 12; i++) begin
      drive32(tab[i].op, tab[i].a, tab[i].b, tab[i].hi, tab[i].lo, tab[i].dbz);
      wait32();
    end

    // A start pulse while busy must have no effect
    drive32(2'd0, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);
    repeat (5) @(negedge clk);
    chk("busy_mid32", {63'b0, d32_busy}, 64'd1);
    s32_op = 2'd2;
    s32_a = 32'd9;
    s32_b = 32'd0;
    s32_start = 1'b1;
    @(negedge clk);
    s32_start = 1'b0;
    wait32();
    repeat (3) @(negedge clk);

    // Back-to-back: second start issued in the done cycle of the first
    drive32(2'd1, 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!d32_done && n < 100);
    drive32(2'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    wait32();

    // Asynchronous reset with the counter at 10
    drive32(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy32", {63'b0, d32_busy}, 64'd0);
    chk("midrst_done32", {63'b0, d32_done}, 64'd0);
    chk("midrst_hi32", {32'b0, d32_hi}, 64'd0);
    chk("midrst_lo32", {32'b0, d32_lo}, 64'd0);
    q32.delete();
    @(negedge clk);
    rst_n = 1'b1;
    drive32(2'd0, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);
    wait32();
    repeat (3) @(negedge clk);

    // Randomised sweep at WIDTH=8 against the integer model
    for (int i = 0; i < 300; i++) begin
      op8 = 2'($urandom_range(0, 3));
      a8 = pick8();
      b8 = (i % 10 == 0) ? 8'd0 : pick8();
      model8(op8, a8, b8, hi8, lo8, dbz8);
      drive8(op8, a8, b8, hi8, lo8, dbz8);
      if (i % 25 == 3) begin
        // Stray start while busy; the monitor flags any extra done
        s8_start = 1'b1;
        @(negedge clk);
        s8_start = 1'b0;
      end
      wait8();
    end
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
